// File: rtl/decoder_nto2n_reg.sv
// Registered N-to-2^N one-hot decoder with enable, valid/ready output and an auto-walking scan mode.
// Optional DECODER_ONEHOT_CHECK_EN adds a sticky one-hot/expected-word checker driving err.
module decoder_nto2n_reg #(
  parameter  int unsigned SEL_W = 3,
  localparam int unsigned OUT_W = 1 << SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] din,
  input  logic             en,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             scan_done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [SEL_W-1:0] ptr_inc;
  logic [OUT_W-1:0] y_q, y_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             scan_done_q, scan_done_d;
  logic             accept;
  logic             xfer;

  assign in_ready = !busy_q && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid_q && out_ready;
  assign ptr_inc  = ptr_q + SEL_W'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      last_q      <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      last_q      <= last_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      scan_done_q <= scan_done_d;
    end
  end

  // Next-state and output logic; everything holds unless a beat moves
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    last_d      = last_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    scan_done_d = scan_done_q;
    case (state_q)
      IDLE, HOLD: begin
        if (accept) begin
          out_valid_d = 1'b1;
          scan_done_d = 1'b0;
          if (mode && en) begin
            ptr_d   = din;
            last_d  = din - SEL_W'(1);
            y_d     = OUT_W'(1) << din;
            busy_d  = 1'b1;
            state_d = SCAN;
          end else begin
            y_d     = en ? (OUT_W'(1) << din) : '0;
            busy_d  = 1'b0;
            state_d = HOLD;
          end
        end else if (xfer) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      SCAN: begin
        if (xfer) begin
          if (scan_done_q) begin
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            scan_done_d = 1'b0;
            state_d     = IDLE;
          end else begin
            ptr_d       = ptr_inc;
            y_d         = OUT_W'(1) << ptr_inc;
            scan_done_d = (ptr_inc == last_q);
          end
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        scan_done_d = 1'b0;
      end
    endcase
  end

  assign y         = y_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign scan_done = scan_done_q;

`ifdef DECODER_ONEHOT_CHECK_EN
  logic [SEL_W-1:0] code_q;
  logic             en_q;
  logic             err_q;
  logic [OUT_W-1:0] exp_word;

  // Expected word rebuilt from the last accepted code, or the walking pointer in scan
  assign exp_word = (state_q == SCAN) ? (OUT_W'(1) << ptr_q)
                                      : (en_q ? (OUT_W'(1) << code_q) : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= '0;
      en_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        code_q <= din;
        en_q   <= en;
      end
      if (out_valid_q && ((y_q != exp_word) || ($countones(y_q) > 1))) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_nto2n_reg.sv
// Self-checking bench for decoder_nto2n_reg: SEL_W=3 instance plus a SEL_W=1 instance, scoreboard-driven.
module tb_decoder_nto2n_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] din;
  logic       en, mode, in_valid, in_ready, out_valid, out_ready, busy, scan_done, err;
  logic [7:0] y;
  logic [0:0] din1;
  logic       en1, mode1, in_valid1, in_ready1, out_valid1, out_ready1, busy1, scan_done1, err1;
  logic [1:0] y1;

  int checks = 0;
  int errors = 0;
  logic [8:0] q[$];
  logic [2:0] q1[$];

  always #5 clk = ~clk;

  decoder_nto2n_reg #(.SEL_W(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .y(y), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .scan_done(scan_done), .err(err)
  );

  decoder_nto2n_reg #(.SEL_W(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .din(din1), .en(en1), .mode(mode1),
    .in_valid(in_valid1), .in_ready(in_ready1), .y(y1), .out_valid(out_valid1),
    .out_ready(out_ready1), .busy(busy1), .scan_done(scan_done1), .err(err1)
  );

  // Scoreboard monitors: one pop per output transfer
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL beat8_unexpected: got {sd,y}=%b, none expected", {scan_done, y});
      end else begin
        logic [8:0] e;
        e = q.pop_front();
        if ({scan_done, y} !== e) begin
          errors++;
          $display("FAIL beat8: got {sd,y}=%b expected %b", {scan_done, y}, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid1 && out_ready1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL beat2_unexpected: got {sd,y}=%b, none expected", {scan_done1, y1});
      end else begin
        logic [2:0] e;
        e = q1.pop_front();
        if ({scan_done1, y1} !== e) begin
          errors++;
          $display("FAIL beat2: got {sd,y}=%b expected %b", {scan_done1, y1}, e);
        end
      end
    end
  end

  task automatic drain(input bit which);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if ((which ? q1.size() : q.size()) == 0) break;
    end
    @(negedge clk);
    checks++;
    if ((which ? q1.size() : q.size()) != 0) begin
      errors++;
      $display("FAIL drain%0d: %0d beats outstanding, expected 0", which, which ? q1.size() : q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({y, out_valid, busy, scan_done, err} !== 12'd0) begin
      errors++;
      $display("FAIL reset_outputs: got y=%h ov=%b busy=%b sd=%b err=%b, expected all 0",
               y, out_valid, busy, scan_done, err);
    end
    checks++;
    if ({y1, out_valid1, busy1, scan_done1, err1} !== 6'd0) begin
      errors++;
      $display("FAIL reset_outputs1: got y=%b ov=%b busy=%b, expected all 0", y1, out_valid1, busy1);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || in_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b/%b expected 1/1", in_ready, in_ready1);
    end
  endtask

  task automatic test_decode();
    logic [7:0] w, prev;
    prev = '0;
    out_ready = 1'b1; mode = 1'b0; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; din = 3'(i);
      w = 8'd1 << i;
      q.push_back({1'b0, w});
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL decode_in_ready: beat %0d got %b expected 1", i, in_ready);
      end
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1 || y !== prev) begin
          errors++;
          $display("FAIL decode_latency: beat %0d got ov=%b y=%h expected ov=1 y=%h", i - 1, out_valid, y, prev);
        end
      end
      prev = w;
    end
    @(posedge clk); #1;
    en = 1'b0; din = 3'd5;
    q.push_back(9'h000);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || y !== 8'h80) begin
      errors++;
      $display("FAIL decode_latency: beat 7 got ov=%b y=%h expected ov=1 y=80", out_valid, y);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; en = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || y !== 8'h00) begin
      errors++;
      $display("FAIL decode_en0: got ov=%b y=%h expected ov=1 y=00", out_valid, y);
    end
    drain(1'b0);
  endtask

  task automatic test_scan_disabled();
    @(posedge clk); #1;
    in_valid = 1'b1; mode = 1'b1; en = 1'b0; din = 3'd4;
    q.push_back(9'h000);
    @(posedge clk); #1;
    in_valid = 1'b0; mode = 1'b0; en = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b1 || y !== 8'h00) begin
      errors++;
      $display("FAIL scan_en0: got busy=%b ov=%b y=%h expected busy=0 ov=1 y=00", busy, out_valid, y);
    end
    drain(1'b0);
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; mode = 1'b0; en = 1'b1; din = 3'd3;
    q.push_back({1'b0, 8'h08});
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (y !== 8'h08 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d got y=%h ov=%b ir=%b expected y=08 ov=1 ir=0",
                 c, y, out_valid, in_ready);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; din = 3'd6;
    q.push_back({1'b0, 8'h40});
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready: got %b expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || y !== 8'h40) begin
      errors++;
      $display("FAIL stall_no_bubble: got ov=%b y=%h expected ov=1 y=40", out_valid, y);
    end
    drain(1'b0);
  endtask

  task automatic test_scan();
    int busy_cnt, viol;
    logic [7:0] w;
    busy_cnt = 0; viol = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; mode = 1'b1; en = 1'b1; din = 3'd6;
    for (int k = 0; k < 8; k++) begin
      w = 8'd1 << ((6 + k) % 8);
      q.push_back({(k == 7) ? 1'b1 : 1'b0, w});
    end
    @(posedge clk); #1;
    in_valid = 1'b0; mode = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (busy === 1'b1 && in_ready !== 1'b0) viol++;
    end
    checks++;
    if (busy_cnt != 8) begin
      errors++;
      $display("FAIL scan_busy_len: got %0d cycles expected 8", busy_cnt);
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL scan_in_ready: got %0d cycles with in_ready high while busy, expected 0", viol);
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL scan_end: got ir=%b ov=%b expected ir=1 ov=0", in_ready, out_valid);
    end
    drain(1'b0);
  endtask

  task automatic test_scan_reset();
    logic [7:0] w;
    @(posedge clk); #1;
    in_valid = 1'b1; mode = 1'b1; en = 1'b1; din = 3'd0;
    for (int k = 0; k < 8; k++) begin
      w = 8'd1 << k;
      q.push_back({(k == 7) ? 1'b1 : 1'b0, w});
    end
    @(posedge clk); #1;
    in_valid = 1'b0; mode = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({y, out_valid, busy, scan_done} !== 11'd0) begin
      errors++;
      $display("FAIL scan_reset_clear: got y=%h ov=%b busy=%b sd=%b expected all 0", y, out_valid, busy, scan_done);
    end
    checks++;
    if (q.size() != 5) begin
      errors++;
      $display("FAIL scan_reset_beats: got %0d beats left expected 5", q.size());
    end
    q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL scan_reset_ready: got %b expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b1; mode = 1'b0; en = 1'b1; din = 3'd2;
    q.push_back({1'b0, 8'h04});
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain(1'b0);
  endtask

  task automatic test_param();
    @(posedge clk); #1;
    in_valid1 = 1'b1; mode1 = 1'b1; en1 = 1'b1; din1 = 1'b1;
    q1.push_back({1'b0, 2'b10});
    q1.push_back({1'b1, 2'b01});
    @(posedge clk); #1;
    in_valid1 = 1'b0; mode1 = 1'b0;
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b1 || in_ready1 !== 1'b0) begin
      errors++;
      $display("FAIL param_busy: got busy=%b ir=%b expected busy=1 ir=0", busy1, in_ready1);
    end
    drain(1'b1);
    checks++;
    if (busy1 !== 1'b0 || in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
      errors++;
      $display("FAIL param_end: got busy=%b ir=%b ov=%b expected 0/1/0", busy1, in_ready1, out_valid1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    din = '0; en = 1'b0; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    din1 = '0; en1 = 1'b0; mode1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b1;
    test_reset();
    test_decode();
    test_scan_disabled();
    test_backpressure();
    test_scan();
    test_scan_reset();
    test_param();
    checks++;
    if (err !== 1'b0 || err1 !== 1'b0) begin
      errors++;
      $display("FAIL err_flag: got %b/%b expected 0/0", err, err1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
